// File: rtl/lcd_ctrl_param.sv
// Image display controller: loads an IMG_DIM x IMG_DIM image from IROM, edits a 2x2 window
// around a movable origin on host commands, and writes the buffer to IRB. Macro LCD_CTRL_ROTATE_EN adds rotate (8/9).
module lcd_ctrl_param #(
    parameter int IMG_DIM = 8,
    parameter int DW      = 8,
    parameter int AW      = $clog2(IMG_DIM * IMG_DIM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);
    localparam int N  = IMG_DIM * IMG_DIM;
    localparam int CW = $clog2(IMG_DIM);
    localparam logic [CW-1:0] ORG0  = CW'(IMG_DIM / 2);
    localparam logic [CW-1:0] CMAX  = CW'(IMG_DIM - 1);
    localparam logic [CW-1:0] CONE  = CW'(1);
    localparam logic [AW-1:0] ALAST = AW'(N - 1);
    localparam logic [AW-1:0] AONE  = AW'(1);

    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          irom_en_q, irom_en_d;
    logic [AW-1:0] irom_a_q, irom_a_d;
    logic          rd_vld_q, rd_vld_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          irb_rw_q, irb_rw_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [AW-1:0] irb_a_q, irb_a_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] mem_q [N];
    logic [DW-1:0] mem_d [N];

    logic [CW-1:0] xm1, ym1;
    logic [AW-1:0] a_tl, a_tr, a_bl, a_br;
    logic [DW-1:0] p_tl, p_tr, p_bl, p_br;
    logic [DW-1:0] n_tl, n_tr, n_bl, n_br;
    logic [DW+1:0] sum;
    logic [DW-1:0] avg, mx_t, mx_b, mx, mn_t, mn_b, mn;

    // Pixel (c,r) lives at {r,c} because IMG_DIM is a power of two.
    always_comb begin
        xm1  = x_q - CONE;
        ym1  = y_q - CONE;
        a_tl = AW'({ym1, xm1});
        a_tr = AW'({ym1, x_q});
        a_bl = AW'({y_q, xm1});
        a_br = AW'({y_q, x_q});
    end

    assign p_tl = mem_q[a_tl];
    assign p_tr = mem_q[a_tr];
    assign p_bl = mem_q[a_bl];
    assign p_br = mem_q[a_br];

    assign sum  = {2'b00, p_tl} + {2'b00, p_tr} + {2'b00, p_bl} + {2'b00, p_br};
    assign avg  = DW'(sum >> 2);
    assign mx_t = (p_tl > p_tr) ? p_tl : p_tr;
    assign mx_b = (p_bl > p_br) ? p_bl : p_br;
    assign mx   = (mx_t > mx_b) ? mx_t : mx_b;
    assign mn_t = (p_tl < p_tr) ? p_tl : p_tr;
    assign mn_b = (p_bl < p_br) ? p_bl : p_br;
    assign mn   = (mn_t < mn_b) ? mn_t : mn_b;

    always_comb begin
        n_tl = p_tl;
        n_tr = p_tr;
        n_bl = p_bl;
        n_br = p_br;
        case (cmd_q)
            4'd5: begin
                n_tl = avg; n_tr = avg; n_bl = avg; n_br = avg;
            end
            4'd6: begin
                n_tl = p_bl; n_bl = p_tl; n_tr = p_br; n_br = p_tr;
            end
            4'd7: begin
                n_tl = p_tr; n_tr = p_tl; n_bl = p_br; n_br = p_bl;
            end
`ifdef LCD_CTRL_ROTATE_EN
            4'd8: begin
                n_tl = p_bl; n_tr = p_tl; n_br = p_tr; n_bl = p_br;
            end
            4'd9: begin
                n_tl = p_tr; n_tr = p_br; n_br = p_bl; n_bl = p_tl;
            end
`endif
            4'd10: begin
                n_tl = mx; n_tr = mx; n_bl = mx; n_br = mx;
            end
            4'd11: begin
                n_tl = mn; n_tr = mn; n_bl = mn; n_br = mn;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        x_d       = x_q;
        y_d       = y_q;
        irom_en_d = irom_en_q;
        irom_a_d  = irom_a_q;
        rd_vld_d  = 1'b0;
        rd_addr_d = irom_a_q;
        irb_rw_d  = irb_rw_q;
        wdata_d   = wdata_q;
        irb_a_d   = irb_a_q;
        busy_d    = busy_q;
        done_d    = done_q;
        case (state_q)
            S_LOAD: begin
                // IROM data returns a cycle after the address, so track which address is landing.
                rd_vld_d = ~irom_en_q;
                if (!irom_en_q) begin
                    if (irom_a_q == ALAST) irom_en_d = 1'b1;
                    else                   irom_a_d  = irom_a_q + AONE;
                end else if (!rd_vld_q) begin
                    irom_en_d = 1'b0;
                end
                if (rd_vld_q && rd_addr_q == ALAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d  = cmd;
                    busy_d = 1'b1;
                    if (cmd == 4'd0) begin
                        state_d  = S_WRITE;
                        irb_rw_d = 1'b0;
                        irb_a_d  = '0;
                        wdata_d  = mem_q[0];
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                case (cmd_q)
                    4'd1: if (y_q != CONE) y_d = y_q - CONE;
                    4'd2: if (y_q != CMAX) y_d = y_q + CONE;
                    4'd3: if (x_q != CONE) x_d = x_q - CONE;
                    4'd4: if (x_q != CMAX) x_d = x_q + CONE;
                    default: ;
                endcase
            end
            S_WRITE: begin
                if (irb_a_q == ALAST) begin
                    irb_rw_d = 1'b1;
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                end else begin
                    irb_a_d = irb_a_q + AONE;
                    wdata_d = mem_q[irb_a_q + AONE];
                end
            end
            S_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == S_LOAD && rd_vld_q) mem_d[rd_addr_q] = IROM_Q;
        if (state_q == S_EXEC) begin
            mem_d[a_tl] = n_tl;
            mem_d[a_tr] = n_tr;
            mem_d[a_bl] = n_bl;
            mem_d[a_br] = n_br;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_LOAD;
            cmd_q     <= '0;
            x_q       <= ORG0;
            y_q       <= ORG0;
            irom_en_q <= 1'b1;
            irom_a_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            irb_rw_q  <= 1'b1;
            wdata_q   <= '0;
            irb_a_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            x_q       <= x_d;
            y_q       <= y_d;
            irom_en_q <= irom_en_d;
            irom_a_q  <= irom_a_d;
            rd_vld_q  <= rd_vld_d;
            rd_addr_q <= rd_addr_d;
            irb_rw_q  <= irb_rw_d;
            wdata_q   <= wdata_d;
            irb_a_q   <= irb_a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Image contents are don't-care after reset; they are always reloaded.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign IROM_EN = irom_en_q;
    assign IROM_A  = irom_a_q;
    assign IRB_RW  = irb_rw_q;
    assign IRB_D   = wdata_q;
    assign IRB_A   = irb_a_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Self-checking bench for lcd_ctrl_param: IROM/IRB models plus a pixel-array reference of the command set.
module tb_lcd_ctrl_param;
    localparam int D  = 8;
    localparam int DW = 8;
    localparam int N  = D * D;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    cmd = '0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] IROM_Q;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] irom [N];
    logic [DW-1:0] irom_q = '0;
    logic [DW-1:0] irb [N];
    int            irb_gen [N];
    int            gen = 0;
    int            done_cnt = 0;

    logic [DW-1:0] img [N];
    int            ox, oy;

    lcd_ctrl_param #(.IMG_DIM(D), .DW(DW), .AW(AW)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
        .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IRB_RW(IRB_RW), .IRB_D(IRB_D), .IRB_A(IRB_A),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign IROM_Q = irom_q;

    always @(posedge clk) begin
        if (IROM_EN === 1'b0) irom_q <= irom[IROM_A];
        if (IRB_RW === 1'b0) begin
            irb[IRB_A]     <= IRB_D;
            irb_gen[IRB_A] <= gen;
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic model_cmd(input int c);
        int a [4];
        int v [4];
        int s;
        a[0] = (oy - 1) * D + (ox - 1);
        a[1] = a[0] + 1;
        a[2] = a[0] + D;
        a[3] = a[2] + 1;
        for (int k = 0; k < 4; k++) v[k] = int'(img[a[k]]);
        case (c)
            1: if (oy > 1) oy--;
            2: if (oy < D - 1) oy++;
            3: if (ox > 1) ox--;
            4: if (ox < D - 1) ox++;
            5: begin
                s = (v[0] + v[1] + v[2] + v[3]) / 4;
                for (int k = 0; k < 4; k++) img[a[k]] = DW'(s);
            end
            6: begin
                img[a[0]] = DW'(v[2]); img[a[2]] = DW'(v[0]);
                img[a[1]] = DW'(v[3]); img[a[3]] = DW'(v[1]);
            end
            7: begin
                img[a[0]] = DW'(v[1]); img[a[1]] = DW'(v[0]);
                img[a[2]] = DW'(v[3]); img[a[3]] = DW'(v[2]);
            end
`ifdef LCD_CTRL_ROTATE_EN
            8: begin
                img[a[0]] = DW'(v[2]); img[a[1]] = DW'(v[0]);
                img[a[3]] = DW'(v[1]); img[a[2]] = DW'(v[3]);
            end
            9: begin
                img[a[0]] = DW'(v[1]); img[a[1]] = DW'(v[3]);
                img[a[3]] = DW'(v[2]); img[a[2]] = DW'(v[0]);
            end
`endif
            10: begin
                s = v[0];
                for (int k = 1; k < 4; k++) if (v[k] > s) s = v[k];
                for (int k = 0; k < 4; k++) img[a[k]] = DW'(s);
            end
            11: begin
                s = v[0];
                for (int k = 1; k < 4; k++) if (v[k] < s) s = v[k];
                for (int k = 0; k < 4; k++) img[a[k]] = DW'(s);
            end
            default: ;
        endcase
    endtask

    // Issue one command from idle; returns the number of busy cycles seen (-1 on timeout).
    task automatic send_cmd(input logic [3:0] c, output int bc);
        int guard = 0;
        while (busy !== 1'b0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd       = 4'($urandom);
        bc        = 0;
        while (busy === 1'b1 && bc < 500) begin
            bc++;
            @(negedge clk);
        end
        if (bc >= 500 || guard >= 500) bc = -1;
    endtask

    // Release reset and measure the load: busy cycles from the first fetch, and fetch-order errors.
    task automatic release_and_load(output int cyc, output int aerr);
        int  exp_a = 0;
        bit  started = 0;
        cyc  = 0;
        aerr = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int g = 0; g < 400; g++) begin
            @(negedge clk);
            if (IROM_EN === 1'b0) begin
                started = 1;
                if (IROM_A !== AW'(exp_a)) aerr++;
                exp_a++;
            end
            if (started) begin
                if (busy === 1'b1) cyc++;
                else break;
            end
        end
        if (exp_a != N) aerr++;
    endtask

    task automatic test_writeback(input string tag);
        int bc, d0, bad;
        gen = gen + 1;
        d0  = done_cnt;
        bad = 0;
        send_cmd(4'd0, bc);
        vectors++;
        if (bc != N + 1) begin
            miscompares++;
            $display("FAIL %s write_busy: got %0d cycles, want %0d", tag, bc, N + 1);
        end
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL %s done_pulses: got %0d, want 1", tag, done_cnt - d0);
        end
        for (int i = 0; i < N; i++) begin
            vectors++;
            if (irb[i] !== img[i] || irb_gen[i] != gen) begin
                miscompares++;
                if (bad < 8)
                    $display("FAIL %s pix[%0d]: got %h (gen %0d), want %h (gen %0d)",
                             tag, i, irb[i], irb_gen[i], img[i], gen);
                bad++;
            end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done} !== {1'b1, 6'd0, 1'b1, 8'd0, 6'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got en=%b ia=%0d rw=%b d=%h a=%0d busy=%b done=%b, want 1 0 1 00 0 1 0",
                     IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done);
        end
    endtask

    task automatic test_load();
        int cyc, aerr;
        for (int i = 0; i < N; i++) irom[i] = DW'(i);
        img = irom;
        ox  = D / 2;
        oy  = D / 2;
        release_and_load(cyc, aerr);
        vectors++;
        if (cyc != N + 1) begin
            miscompares++;
            $display("FAIL load_cycles: got %0d, want %0d", cyc, N + 1);
        end
        vectors++;
        if (aerr != 0) begin
            miscompares++;
            $display("FAIL load_addr: got %0d errors, want 0", aerr);
        end
        test_writeback("load");
    endtask

    task automatic test_exec(input int c, input string tag);
        int bc;
        send_cmd(4'(c), bc);
        vectors++;
        if (bc != 1) begin
            miscompares++;
            $display("FAIL %s exec_busy cmd %0d: got %0d cycles, want 1", tag, c, bc);
        end
        model_cmd(c);
    endtask

    task automatic test_rotate();
        test_exec(8, "rotate");
        test_writeback("rotate");
    endtask

    task automatic test_average();
        test_exec(5, "average");
        test_writeback("average");
    endtask

    task automatic test_max();
        test_exec(10, "max");
        test_writeback("max1");
        test_writeback("max2");
    endtask

    task automatic test_shift();
        for (int k = 0; k < 4; k++) test_exec(1, "up");
        for (int k = 0; k < 3; k++) test_exec(3, "left");
        test_exec(6, "mirror_x");
        test_writeback("corner_tl");
        for (int k = 0; k < 8; k++) test_exec(4, "right");
        for (int k = 0; k < 8; k++) test_exec(2, "down");
        test_exec(11, "min");
        test_exec(7, "mirror_y");
        test_writeback("corner_br");
    endtask

    task automatic test_back_to_back();
        int guard = 0;
        @(negedge clk);
        cmd       = 4'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_accept: busy got %b, want 1", busy);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_exec_len: busy got %b, want 0", busy);
        end
        while (busy !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        model_cmd(3);
        test_exec(5, "b2b_avg");
        test_writeback("b2b");
    endtask

    task automatic test_abort();
        int cyc, aerr, d0;
        bit hit = 0;
        cmd       = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int g = 0; g < 200; g++) begin
            if (IRB_RW === 1'b0 && IRB_A === 6'd20) begin
                hit = 1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL abort_reach: write cycle 20 got not reached, want reached");
        end
        reset = 1'b0;
        #1;
        vectors++;
        if ({IRB_RW, busy, IROM_EN, done} !== 4'b1110) begin
            miscompares++;
            $display("FAIL abort_outputs: got rw=%b busy=%b en=%b done=%b, want 1 1 1 0",
                     IRB_RW, busy, IROM_EN, done);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < N; i++) irom[i] = DW'($urandom);
        img = irom;
        ox  = D / 2;
        oy  = D / 2;
        d0  = done_cnt;
        release_and_load(cyc, aerr);
        vectors++;
        if (cyc != N + 1 || aerr != 0) begin
            miscompares++;
            $display("FAIL reload: got %0d cycles / %0d addr errors, want %0d / 0", cyc, aerr, N + 1);
        end
        vectors++;
        if (done_cnt != d0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d pulses, want 0", done_cnt - d0);
        end
        test_exec(5, "abort_avg");
        test_writeback("abort");
    endtask

    task automatic test_random();
        for (int it = 0; it < 60; it++) begin
            test_exec(int'($urandom_range(1, 15)), "random");
            if (it % 20 == 19) test_writeback("random");
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_rotate();
        test_average();
        test_max();
        test_shift();
        test_back_to_back();
        test_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
